// File: rtl/mac_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : mac_accumulator
//  Purpose  : Multi-step signed multiply-accumulate over a rotating X buffer.
//             Each RUN step multiplies NUM_TAPS unsigned X bytes by signed
//             coefficients, registers the products, then folds their sum into
//             a wrapping accumulator one cycle later. The result is held
//             under a valid/ready handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module mac_accumulator #(
  parameter int NUM_TAPS  = 7,
  parameter int DATA_W    = 8,
  parameter int NUM_STEPS = 9,
  parameter int ACC_W     = 24
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         clear,
  input  logic                         load_done,
  input  logic [NUM_TAPS*DATA_W-1:0]   X_reg,
  input  logic [NUM_TAPS*DATA_W-1:0]   coef,
  output logic                         X_shift,
  output logic [3:0]                   shift_count,
  output logic                         busy,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [ACC_W-1:0]             result
);

  // Product of a zero-extended X byte and a sign-extended coefficient
  localparam int PROD_W = 2*DATA_W + 1;
  localparam int CNT_W  = 4;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NUM_STEPS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          shift_count_q, shift_count_d;
  logic signed [PROD_W-1:0]  prod_q [NUM_TAPS];
  logic signed [PROD_W-1:0]  prod_d [NUM_TAPS];
  logic [ACC_W-1:0]          acc_q, acc_d;
  logic                      x_shift_q, x_shift_d;
  logic                      busy_q, busy_d;
  logic                      res_valid_q, res_valid_d;

  logic signed [PROD_W-1:0]  prod_w [NUM_TAPS];
  logic [ACC_W-1:0]          prod_sum;

  // Per-tap multipliers; operands are widened to the product width first so
  // the multiply is evaluated at full precision.
  for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
    logic signed [PROD_W-1:0] x_ext;
    logic signed [PROD_W-1:0] c_ext;
    assign x_ext     = {{(PROD_W-DATA_W){1'b0}}, X_reg[k*DATA_W +: DATA_W]};
    assign c_ext     = {{(PROD_W-DATA_W){coef[k*DATA_W+DATA_W-1]}},
                        coef[k*DATA_W +: DATA_W]};
    assign prod_w[k] = x_ext * c_ext;
  end

  // Sign-extend and sum the registered stage-1 products
  always_comb begin
    prod_sum = '0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      prod_sum = prod_sum + {{(ACC_W-PROD_W){prod_q[k][PROD_W-1]}}, prod_q[k]};
    end
  end

  // Next-state and next-output logic; clear overrides everything else
  always_comb begin
    state_d       = state_q;
    shift_count_d = shift_count_q;
    acc_d         = acc_q;
    x_shift_d     = x_shift_q;
    busy_d        = busy_q;
    res_valid_d   = res_valid_q;
    for (int k = 0; k < NUM_TAPS; k++) prod_d[k] = '0;

    case (state_q)
      S_IDLE: begin
        if (start && load_done) begin
          state_d       = S_RUN;
          shift_count_d = '0;
          acc_d         = '0;
          x_shift_d     = 1'b1;
          busy_d        = 1'b1;
        end
      end
      S_RUN: begin
        for (int k = 0; k < NUM_TAPS; k++) prod_d[k] = prod_w[k];
        acc_d = acc_q + prod_sum;
        if (shift_count_q == LAST_STEP) begin
          state_d       = S_DRAIN;
          shift_count_d = '0;
          x_shift_d     = 1'b0;
        end else begin
          shift_count_d = shift_count_q + 1'b1;
        end
      end
      S_DRAIN: begin
        acc_d       = acc_q + prod_sum;
        state_d     = S_DONE;
        res_valid_d = 1'b1;
      end
      S_DONE: begin
        if (res_ready) begin
          state_d     = S_IDLE;
          res_valid_d = 1'b0;
          busy_d      = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (clear) begin
      state_d       = S_IDLE;
      shift_count_d = '0;
      acc_d         = '0;
      x_shift_d     = 1'b0;
      busy_d        = 1'b0;
      res_valid_d   = 1'b0;
      for (int k = 0; k < NUM_TAPS; k++) prod_d[k] = '0;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      shift_count_q <= '0;
      acc_q         <= '0;
      x_shift_q     <= 1'b0;
      busy_q        <= 1'b0;
      res_valid_q   <= 1'b0;
      for (int k = 0; k < NUM_TAPS; k++) prod_q[k] <= '0;
    end else begin
      state_q       <= state_d;
      shift_count_q <= shift_count_d;
      acc_q         <= acc_d;
      x_shift_q     <= x_shift_d;
      busy_q        <= busy_d;
      res_valid_q   <= res_valid_d;
      for (int k = 0; k < NUM_TAPS; k++) prod_q[k] <= prod_d[k];
    end
  end

  assign X_shift     = x_shift_q;
  assign shift_count = shift_count_q;
  assign busy        = busy_q;
  assign res_valid   = res_valid_q;
  assign result      = acc_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mac_accumulator
//  Purpose  : Directed self-checking bench for mac_accumulator.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mac_accumulator;

  logic        clk;
  logic        rst;
  logic        start;
  logic        clear;
  logic        load_done;
  logic [55:0] X_reg;
  logic [55:0] coef;
  logic        X_shift;
  logic [3:0]  shift_count;
  logic        busy;
  logic        res_valid;
  logic        res_ready;
  logic [23:0] result;

  int n_total = 0;
  int n_pass  = 0;

  mac_accumulator dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .clear       (clear),
    .load_done   (load_done),
    .X_reg       (X_reg),
    .coef        (coef),
    .X_shift     (X_shift),
    .shift_count (shift_count),
    .busy        (busy),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .result      (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start with load_done for one edge; leaves the DUT in its first RUN cycle
  task automatic kick();
    start     = 1'b1;
    load_done = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  // Runs an accumulation from the first RUN cycle up to the first DONE cycle
  task automatic run_to_done(input string tag);
    for (int i = 0; i < 9; i++) begin
      check({tag, "_xshift"}, 32'(X_shift), 32'd1);
      check({tag, "_cnt"}, 32'(shift_count), 32'(i));
      tick();
    end
    check({tag, "_drain_xshift"}, 32'(X_shift), 32'd0);
    check({tag, "_drain_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_drain_busy"}, 32'(busy), 32'd1);
    tick();
  endtask

  initial begin
    rst       = 1'b0;
    start     = 1'b0;
    clear     = 1'b0;
    load_done = 1'b0;
    res_ready = 1'b0;
    X_reg     = '0;
    coef      = '0;

    // Reset state
    #2;
    check("rst_xshift", 32'(X_shift), 32'd0);
    check("rst_cnt", 32'(shift_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(res_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // start without load_done is ignored
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("noload_busy", 32'(busy), 32'd0);
      check("noload_xshift", 32'(X_shift), 32'd0);
    end
    start = 1'b0;

    // All-ones pattern: 7 taps x 9 steps x 1 = 63, with backpressure and start in DONE
    X_reg = 56'h01_01_01_01_01_01_01;
    coef  = 56'h01_01_01_01_01_01_01;
    kick();
    run_to_done("ones");
    check("ones_valid", 32'(res_valid), 32'd1);
    check("ones_result", 32'(result), 32'd63);
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      tick();
      check("bp_valid", 32'(res_valid), 32'd1);
      check("bp_result", 32'(result), 32'd63);
      check("bp_busy", 32'(busy), 32'd1);
    end
    start     = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("hs_valid", 32'(res_valid), 32'd0);
    check("hs_busy", 32'(busy), 32'd0);
    check("hs_cnt", 32'(shift_count), 32'd0);

    // 0xFF x -128 everywhere: 63 x -32640 = -2056320 = 0xE09F80 (24-bit);
    // res_ready already high when valid rises, load_done dropped during RUN
    X_reg     = 56'hFF_FF_FF_FF_FF_FF_FF;
    coef      = 56'h80_80_80_80_80_80_80;
    res_ready = 1'b1;
    kick();
    load_done = 1'b0;
    run_to_done("neg");
    check("neg_valid", 32'(res_valid), 32'd1);
    check("neg_result", 32'(result), 32'h00E0_9F80);
    tick();
    check("neg_hs_valid", 32'(res_valid), 32'd0);
    check("neg_hs_busy", 32'(busy), 32'd0);

    // Mixed taps: X byte k = k+1, coef byte k = k-3 -> 28 per step, 252 total
    X_reg = 56'h07_06_05_04_03_02_01;
    coef  = 56'h03_02_01_00_FF_FE_FD;
    kick();
    run_to_done("mix");
    check("mix_valid", 32'(res_valid), 32'd1);
    check("mix_result", 32'(result), 32'd252);
    tick();
    res_ready = 1'b0;

    // clear at shift_count 4 aborts; then a clean rerun gives 63
    X_reg = 56'h01_01_01_01_01_01_01;
    coef  = 56'h01_01_01_01_01_01_01;
    kick();
    for (int i = 0; i < 4; i++) tick();
    check("clr_cnt_before", 32'(shift_count), 32'd4);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_busy", 32'(busy), 32'd0);
    check("clr_xshift", 32'(X_shift), 32'd0);
    check("clr_cnt", 32'(shift_count), 32'd0);
    check("clr_result", 32'(result), 32'd0);
    load_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("clr_no_valid", 32'(res_valid), 32'd0);
    end
    // clear wins over start in the same cycle
    clear     = 1'b1;
    start     = 1'b1;
    load_done = 1'b1;
    tick();
    clear = 1'b0;
    start = 1'b0;
    check("clr_prio_busy", 32'(busy), 32'd0);
    kick();
    run_to_done("rerun");
    check("rerun_valid", 32'(res_valid), 32'd1);
    check("rerun_result", 32'(result), 32'd63);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;

    // Asynchronous reset mid-RUN clears outputs immediately
    kick();
    tick();
    tick();
    check("arst_pre_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check("arst_xshift", 32'(X_shift), 32'd0);
    check("arst_cnt", 32'(shift_count), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_valid", 32'(res_valid), 32'd0);
    check("arst_result", 32'(result), 32'd0);
    tick();
    rst       = 1'b1;
    load_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("arst_idle_busy", 32'(busy), 32'd0);
      check("arst_no_valid", 32'(res_valid), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
